// File: rtl/ext_mem_burst_reader.sv
// Burst read initiator: issues single-word reads to a 1-cycle-latency memory and
// streams the returned words out through a small credit-protected capture FIFO.
module ext_mem_burst_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining, total, popped;
  logic              inflight;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              issue, push, pop, accept;

  // Credit: a read is only issued if a FIFO slot is guaranteed for its return,
  // so backpressure can never drop memory data.
  assign issue   = (state == RUN) && (remaining != '0) &&
                   (({{PW{1'b0}}, inflight} + count) < DEPTH);
  assign mem_re  = issue && !rst;
  assign mem_rd_addr = addr;
  assign accept  = (state == IDLE) && start;
  assign push    = inflight;
  assign m_valid = (count != '0);
  assign m_data  = fifo[rd_ptr];
  assign m_last  = m_valid && ((popped + LEN_W'(1)) == total);
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (length == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (issue && remaining == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && m_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      total     <= '0;
      popped    <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (accept) begin
        addr      <= start_addr;
        remaining <= length;
        total     <= length;
        popped    <= '0;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (push) begin
        fifo[wr_ptr] <= mem_rdata;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        popped <= popped + LEN_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_burst_reader.sv
// Directed bench for ext_mem_burst_reader with a 1-cycle-latency memory model
// and a negedge monitor logging reads, beats and done pulses per cycle.
module tb_ext_mem_burst_reader;
  logic        clk = 1'b0;
  logic        rst, start, m_ready;
  logic [15:0] start_addr, length;
  logic        busy, done, mem_re, m_valid, m_last;
  logic [15:0] mem_rd_addr, m_data;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [65536];

  ext_mem_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_rd_addr(mem_rd_addr),
    .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_rd_addr];

  int          rd_cyc[$], beat_cyc[$], done_cyc[$];
  logic [15:0] rd_addr_q[$], beat_data[$];
  logic        beat_last[$];
  int          out_cnt = 0, max_out = 0, stab_err = 0;
  logic        hold = 1'b0, hl = 1'b0;
  logic [15:0] hd = '0;

  always @(negedge clk) begin
    if (rst) begin
      out_cnt = 0;
      hold    = 1'b0;
    end else begin
      if (mem_re) begin rd_cyc.push_back(cyc); rd_addr_q.push_back(mem_rd_addr); end
      if (m_valid && m_ready) begin
        beat_cyc.push_back(cyc); beat_data.push_back(m_data); beat_last.push_back(m_last);
      end
      if (done) done_cyc.push_back(cyc);
      if (hold && (!m_valid || m_data !== hd || m_last !== hl)) stab_err++;
      hold = m_valid && !m_ready;
      hd   = m_data;
      hl   = m_last;
      out_cnt += int'(mem_re) - int'(m_valid && m_ready);
      if (out_cnt > max_out) max_out = out_cnt;
    end
  end

  int passes = 0, total = 0, t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr_q.delete(); beat_cyc.delete();
    beat_data.delete(); beat_last.delete(); done_cyc.delete();
  endtask

  // Called just after a posedge; the start pulse occupies cycle t0.
  task automatic kick(input logic [15:0] a, input logic [15:0] n);
    start = 1'b1; start_addr = a; length = n; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cyc.size() == 0 && k < budget) begin @(posedge clk); #1; k++; end
    chk("done_seen", 32'(done_cyc.size() != 0), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] base, input int n,
                             input logic timed);
    logic [15:0] a;
    chk({tag, "_nreads"}, 32'(rd_addr_q.size()), 32'(n));
    chk({tag, "_nbeats"}, 32'(beat_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      chk({tag, "_addr"}, (i < rd_addr_q.size()) ? 32'(rd_addr_q[i]) : 32'hDEAD_BEEF, 32'(a));
      chk({tag, "_data"}, (i < beat_data.size()) ? 32'(beat_data[i]) : 32'hDEAD_BEEF, 32'(mem[a]));
      chk({tag, "_last"}, (i < beat_last.size()) ? 32'(beat_last[i]) : 32'hDEAD_BEEF,
          32'(i == n - 1));
      if (timed) begin
        chk({tag, "_rdcyc"}, (i < rd_cyc.size()) ? 32'(rd_cyc[i]) : 32'hDEAD_BEEF, 32'(t0 + 1 + i));
        chk({tag, "_btcyc"}, (i < beat_cyc.size()) ? 32'(beat_cyc[i]) : 32'hDEAD_BEEF, 32'(t0 + 3 + i));
      end
    end
    if (timed)
      chk({tag, "_donecyc"}, (done_cyc.size() != 0) ? 32'(done_cyc[0]) : 32'hDEAD_BEEF, 32'(t0 + n + 3));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hC3C3;
    mem[16'h10] = 16'hA0A0; mem[16'h11] = 16'hA1A1;
    mem[16'h12] = 16'hA2A2; mem[16'h13] = 16'hA3A3;
    rst = 1'b1; start = 1'b0; m_ready = 1'b1; start_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'({busy, done, mem_re, m_valid, m_last}), 32'd0);
    chk("reset_data", 32'(m_data), 32'd0);
    chk("reset_addr", 32'(mem_rd_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    clear_logs(); kick(16'h0010, 16'd4); wait_done(50);
    check_burst("basic", 16'h0010, 4, 1'b1);

    // Backpressure: reads stop at the FIFO depth and the head word holds.
    clear_logs(); m_ready = 1'b0; kick(16'h0100, 16'd8);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bp_reads", 32'(rd_addr_q.size()), 32'd4);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'(mem[16'h0100]));
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(60);
    check_burst("bp", 16'h0100, 8, 1'b0);

    clear_logs(); kick(16'hFFFE, 16'd4); wait_done(50);
    check_burst("wrap", 16'hFFFE, 4, 1'b1);

    clear_logs(); kick(16'h0200, 16'd0); wait_done(10);
    chk("zero_donecyc", (done_cyc.size() != 0) ? 32'(done_cyc[0]) : 32'hDEAD_BEEF, 32'(t0 + 1));
    chk("zero_reads", 32'(rd_addr_q.size()), 32'd0);
    chk("zero_beats", 32'(beat_data.size()), 32'd0);

    clear_logs(); kick(16'h0300, 16'd1); wait_done(20);
    check_burst("one", 16'h0300, 1, 1'b1);

    // Second start mid-burst must be ignored.
    clear_logs(); kick(16'h0020, 16'd6);
    start = 1'b1; start_addr = 16'h0050; length = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    repeat (4) begin @(posedge clk); #1; end
    check_burst("busy_start", 16'h0020, 6, 1'b1);

    // Reset mid-RUN, then a fresh burst.
    clear_logs(); kick(16'h0030, 16'd8);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gate_re", 32'(mem_re), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", 32'({busy, done, mem_re, m_valid, m_last}), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);
    @(posedge clk); #1;
    clear_logs(); kick(16'h0040, 16'd3); wait_done(50);
    check_burst("post_rst", 16'h0040, 3, 1'b1);

    chk("no_overflow", 32'(max_out <= 4), 32'd1);
    chk("hold_stable", 32'(stab_err), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/ext_mem_burst_reader.md
Name: ext_mem_burst_reader

Overview:
Read initiator for the external memory model. It takes a start address and word count, issues single-word reads on the memory's read port (re/rd_addr, 1-cycle read latency), and captures the returned data in a small FIFO. The data leaves on a valid/ready stream toward on-chip buffers. Credit-based issue means memory data is never lost under downstream backpressure.

Parameters:
ADDR_W, 16, external memory address width (matches `ADDR_EXT_RAM)
DATA_W, 16, external memory word width (matches `WID_EXT_RAM)
LEN_W, 16, width of burst length field
FIFO_DEPTH, 4, capture FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request pulse; accepted only in IDLE
start_addr  in  ADDR_W  first word address, sampled with accepted start
length  in  LEN_W  number of words, sampled with accepted start
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
mem_re  out  1  read enable to external memory
mem_rd_addr  out  ADDR_W  read address to external memory
mem_rdata  in  DATA_W  memory read data; valid 1 cycle after mem_re
m_valid  out  1  stream data valid
m_ready  in  1  stream consumer ready
m_data  out  DATA_W  stream data
m_last  out  1  marks the final word of the burst, qualified by m_valid

Behaviour:
- Reset: state=IDLE; busy=0, done=0, mem_re=0, mem_rd_addr=0, m_valid=0, m_last=0, m_data=0. FIFO, counters and the in-flight flag are cleared. Any in-flight read return is discarded.
- While rst=1, mem_re is forced to 0 regardless of state (gated combinationally).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches addr<=start_addr, remaining<=length, total<=length.
  - length!=0 -> RUN.
  - length==0 -> DONE; no memory reads and no stream beats occur.
- start is ignored in any state other than IDLE.
- RUN:
  - Issue condition: mem_re = (remaining!=0) && (inflight + fifo_count < FIFO_DEPTH).
  - mem_rd_addr = current addr.
  - On each issue: addr<=addr+1, wrapping modulo 2^ADDR_W. remaining<=remaining-1.
  - inflight is a 1-bit register, set to mem_re each cycle.
  - When inflight=1, mem_rdata is pushed into the FIFO that cycle.
  - When remaining reaches 0 after an issue -> DRAIN.
- DRAIN: no issues. Stay until the handshake on the beat with m_last=1, then -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. A start presented during DONE is ignored.
- busy=1 in RUN and DRAIN only.
- Stream:
  - m_valid=1 whenever the FIFO is non-empty; m_data is the FIFO head.
  - A pop occurs on m_valid && m_ready.
  - m_data and m_last must stay stable while m_valid=1 and m_ready=0.
- m_last=1 when the head word is word number total (counted by a popped-beat counter).
- Push and pop in the same cycle leave fifo_count unchanged. The FIFO never overflows because of the credit rule; the bench asserts this.
- Timing from a start accepted at cycle T:
  - busy=1 and first mem_re at T+1.
  - Data is captured at T+2.
  - m_valid=1 at T+3.
- Throughput: 1 word/cycle sustained with m_ready held high.
- Length 1: a single beat with m_last=1.

Test Plan:
- Basic burst: start_addr=0x0010, length=4, m_ready=1, memory preloaded mem[0x10..0x13]=A0..A3 -> mem_re high at T+1..T+4 with addr 0x10..0x13; beats A0..A3 at T+3..T+6; m_last on A3; done at T+7.
- Backpressure: length=8, m_ready=0 for 10 cycles after start -> at most 4 reads issued, m_data holds A0 stable; release m_ready -> all 8 words in order, no loss or duplication.
- Wrap: start_addr=0xFFFE, length=4 -> read addresses FFFE, FFFF, 0000, 0001; data matches the memory at those addresses.
- Zero/one length: length=0 -> done one cycle after start, mem_re never asserted, m_valid never asserted. length=1 -> one beat with m_last=1.
- Start while busy: second start (addr 0x50) mid-burst -> ignored, only the first burst's words are delivered. Reset: rst=1 mid-RUN -> next cycle all outputs 0, state IDLE; a new start after reset runs a correct burst.
